// File: rtl/mem_io_pkg.sv
// Shared definitions for mem_io_ctrl: FSM state encoding, default widths
// and the mprj_io pad bit positions of the memory-port strobes and buses.
package mem_io_pkg;

    localparam int AW_DEF = 6;
    localparam int DW_DEF = 8;

    localparam int IO_RD_BIT   = 0;
    localparam int IO_WR_BIT   = 3;
    localparam int IO_DATA_LSB = 8;
    localparam int IO_ADDR_LSB = 25;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RWAIT,
        DRIVE,
        WAIT_LOW
    } state_e;

endpackage

// File: rtl/mem_io_sync.sv
// STAGES-deep synchronizer for asynchronous pad inputs, with a per-bit
// rising-edge pulse derived from the synchronized copy.
module mem_io_sync
    import mem_io_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int W      = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] stage_q [STAGES];
    logic [W-1:0] prev_q;

    // NOTE: non-blocking assignments let every stage sample its predecessor's
    // old value, so the chain shifts by exactly one flop per clock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[STAGES-1];
        end
    end

    assign q_o    = stage_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// Pad-to-array bridge: synchronizes mprj_io strobes into one-cycle array
// requests and drives read data back to the pads. Optional macro: MEM_IO_PARITY_EN.
module mem_io_ctrl
    import mem_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 1,
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          io_wr_en_i,
    input  logic          io_rd_en_i,
    input  logic [AW-1:0] io_addr_i,
    input  logic [DW-1:0] io_data_i,
    output logic [DW-1:0] io_data_o,
    output logic [DW-1:0] io_data_oeb,
    output logic          mem_we_o,
    output logic          mem_re_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o,
    output logic          err_o,
    output logic          rd_par_o
);

    localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] oeb_q, oeb_d;
    logic          err_q, err_d;
    logic          we_q, re_q;

    logic          wr_sync, rd_sync, wr_rise, rd_rise;
    logic [AW-1:0] addr_sync;
    logic [DW-1:0] data_sync;
    logic [AW+DW-1:0] unused_vec_rise;
    logic          load_rd, release_rd;

    mem_io_sync #(.STAGES(SYNC_STAGES), .W(1)) u_sync_wr (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .d_i    (io_wr_en_i),
        .q_o    (wr_sync),
        .rise_o (wr_rise)
    );

    mem_io_sync #(.STAGES(SYNC_STAGES), .W(1)) u_sync_rd (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .d_i    (io_rd_en_i),
        .q_o    (rd_sync),
        .rise_o (rd_rise)
    );

    mem_io_sync #(.STAGES(SYNC_STAGES), .W(AW + DW)) u_sync_bus (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .d_i    ({io_addr_i, io_data_i}),
        .q_o    ({addr_sync, data_sync}),
        .rise_o (unused_vec_rise)
    );

    assign load_rd    = (state_q == RWAIT) && (cnt_q == CNT_LAST);
    assign release_rd = (state_q == DRIVE) && !rd_sync;

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        oeb_d   = oeb_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (wr_rise && rd_rise) begin
                    err_d = 1'b1;
                end else if (wr_rise) begin
                    state_d = WRITE;
                    addr_d  = addr_sync;
                    wdata_d = data_sync;
                end else if (rd_rise) begin
                    state_d = READ;
                    addr_d  = addr_sync;
                end
            end
            WRITE:    state_d = WAIT_LOW;
            READ: begin
                state_d = RWAIT;
                cnt_d   = '0;
            end
            RWAIT: begin
                if (load_rd) begin
                    rdata_d = mem_rdata_i;
                    oeb_d   = '0;
                    state_d = DRIVE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DRIVE: begin
                if (release_rd) begin
                    oeb_d   = '1;
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!wr_sync) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase

        // Strobe edges arriving mid-operation are dropped but remembered.
        if ((state_q != IDLE) && (wr_rise || rd_rise)) err_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            oeb_q   <= '1;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            oeb_q   <= oeb_d;
            err_q   <= err_d;
            we_q    <= (state_q == WRITE);
            re_q    <= (state_q == READ);
        end
    end

    assign io_data_o   = rdata_q;
    assign io_data_oeb = oeb_q;
    assign mem_we_o    = we_q;
    assign mem_re_o    = re_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;

`ifdef MEM_IO_PARITY_EN
    logic par_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            par_q <= 1'b0;
        end else if (load_rd) begin
            par_q <= ^mem_rdata_i;
        end else if (release_rd) begin
            par_q <= 1'b0;
        end
    end

    assign rd_par_o = par_q;
`else
    assign rd_par_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl: directed pad transactions, a
// latency/scoreboard model of the expected array and pad behaviour.
module tb_mem_io_ctrl;
    import mem_io_pkg::*;

    localparam int S      = 2;
    localparam int RD_LAT = 1;
    localparam int AW     = AW_DEF;
    localparam int DW     = DW_DEF;

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [37:0]   mprj_io;
    logic [DW-1:0] io_data_o, io_data_oeb, mem_wdata_o, mem_rdata_i;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o, mem_re_o, busy_o, err_o, rd_par_o;

    logic [DW-1:0] ram [64];
    logic [DW-1:0] exp_mem [64];
    logic          load_ram;
    txn_t          exp_q [$];

    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    int            we_count = 0;
    int            re_count = 0;
    int            drive_due = 0;
    int            rd_fall_cyc = 0;
    logic [DW-1:0] rd_exp = '0;
    logic [DW-1:0] prev_oeb = '1;
    bit            busy_seen = 1'b0;

    mem_io_ctrl #(.SYNC_STAGES(S), .RD_LAT(RD_LAT), .AW(AW), .DW(DW)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .io_wr_en_i  (mprj_io[IO_WR_BIT]),
        .io_rd_en_i  (mprj_io[IO_RD_BIT]),
        .io_addr_i   (mprj_io[IO_ADDR_LSB +: AW]),
        .io_data_i   (mprj_io[IO_DATA_LSB +: DW]),
        .io_data_o   (io_data_o),
        .io_data_oeb (io_data_oeb),
        .mem_we_o    (mem_we_o),
        .mem_re_o    (mem_re_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .rd_par_o    (rd_par_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 7 + 3);
    endfunction

    // Array model: RD_LAT=1 data is presented while mem_re_o is high, junk otherwise.
    always @(posedge clk) begin
        if (load_ram) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
        end else if (mem_we_o) begin
            ram[mem_addr_o] <= mem_wdata_o;
        end
    end

    assign mem_rdata_i = mem_re_o ? ram[mem_addr_o] : 8'h5C;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the scoreboard and the pad-protocol rules.
    always @(negedge clk) begin
        txn_t t;
        if (rst) begin
            prev_oeb = io_data_oeb;
        end else begin
            if (busy_o) busy_seen = 1'b1;
            if (mem_we_o || mem_re_o) check("we_re_exclusive", {31'd0, mem_we_o & mem_re_o}, 0);
            if (mem_we_o) begin
                we_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_we", {31'd0, mem_we_o}, 0);
                end else begin
                    t = exp_q.pop_front();
                    check("we_kind", {31'd0, t.is_wr}, 1);
                    check("we_addr", {26'd0, mem_addr_o}, {26'd0, t.addr});
                    check("we_data", {24'd0, mem_wdata_o}, {24'd0, t.data});
                    check("we_cycle", cyc, t.due);
                end
            end
            if (mem_re_o) begin
                re_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_re", {31'd0, mem_re_o}, 0);
                end else begin
                    t = exp_q.pop_front();
                    check("re_kind", {31'd0, t.is_wr}, 0);
                    check("re_addr", {26'd0, mem_addr_o}, {26'd0, t.addr});
                    check("re_cycle", cyc, t.due);
                    rd_exp    = t.data;
                    drive_due = cyc + RD_LAT;
                end
            end
            check("oeb_all_or_none", {31'd0, (io_data_oeb == '0) || (io_data_oeb == '1)}, 1);
            if (prev_oeb == '1 && io_data_oeb == '0) check("drive_cycle", cyc, drive_due);
            if (prev_oeb == '0 && io_data_oeb == '1) check("release_cycle", cyc, rd_fall_cyc + S + 1);
            if (io_data_oeb == '0) begin
                check("drive_data", {24'd0, io_data_o}, {24'd0, rd_exp});
                check("drive_busy", {31'd0, busy_o}, 1);
            end
`ifdef MEM_IO_PARITY_EN
            check("rd_par", {31'd0, rd_par_o}, {31'd0, (io_data_oeb == '0) ? ^rd_exp : 1'b0});
`else
            check("rd_par", {31'd0, rd_par_o}, 0);
`endif
            prev_oeb = io_data_oeb;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_io_data"}, {24'd0, io_data_o}, 0);
        check({tag, "_oeb"}, {24'd0, io_data_oeb}, 32'hFF);
        check({tag, "_we"}, {31'd0, mem_we_o}, 0);
        check({tag, "_re"}, {31'd0, mem_re_o}, 0);
        check({tag, "_addr"}, {26'd0, mem_addr_o}, 0);
        check({tag, "_wdata"}, {24'd0, mem_wdata_o}, 0);
        check({tag, "_busy"}, {31'd0, busy_o}, 0);
        check({tag, "_err"}, {31'd0, err_o}, 0);
        check({tag, "_par"}, {31'd0, rd_par_o}, 0);
    endtask

    task automatic pad_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int hold);
        txn_t t;
        mprj_io[IO_ADDR_LSB +: AW] = addr;
        mprj_io[IO_DATA_LSB +: DW] = data;
        step(S + 1);
        mprj_io[IO_WR_BIT] = 1'b1;
        t = '{is_wr: 1'b1, addr: addr, data: data, due: cyc + S + 2};
        exp_q.push_back(t);
        exp_mem[addr] = data;
        step(hold);
        mprj_io[IO_WR_BIT] = 1'b0;
        step(S + 2);
    endtask

    task automatic rd_begin(input logic [AW-1:0] addr);
        txn_t t;
        mprj_io[IO_ADDR_LSB +: AW] = addr;
        step(S + 1);
        mprj_io[IO_RD_BIT] = 1'b1;
        t = '{is_wr: 1'b0, addr: addr, data: exp_mem[addr], due: cyc + S + 2};
        exp_q.push_back(t);
    endtask

    task automatic rd_end();
        mprj_io[IO_RD_BIT] = 1'b0;
        rd_fall_cyc = cyc;
        step(S + 2);
    endtask

    initial begin
        int base_we, base_re;
        mprj_io  = '0;
        rst      = 1'b1;
        load_ram = 1'b1;
        for (int i = 0; i < 64; i++) exp_mem[i] = init_val(i);
        step(3);
        check_reset("reset");
        load_ram = 1'b0;
        rst      = 1'b0;
        step(2);

        // Single write held high for 20 cycles: exactly one array write.
        base_we = we_count;
        pad_write(6'h39, 8'hFA, 20);
        check("hold_one_pulse", we_count - base_we, 1);
        check("ram_0x39", {24'd0, ram[6'h39]}, 32'hFA);

        pad_write(6'h18, 8'hEA, 4);
        check("ram_0x18", {24'd0, ram[6'h18]}, 32'hEA);

        rd_begin(6'h39);
        step(S + 2 + RD_LAT + 2);
        check("read_data", {24'd0, io_data_o}, 32'hFA);
        check("read_oeb", {24'd0, io_data_oeb}, 32'h00);
        check("read_busy", {31'd0, busy_o}, 1);
        rd_end();
        check("release_oeb", {24'd0, io_data_oeb}, 32'hFF);
        check("release_data_kept", {24'd0, io_data_o}, 32'hFA);
        check("no_err_yet", {31'd0, err_o}, 0);

        // Address-range boundary.
        pad_write(6'h3F, 8'h81, 3);
        rd_begin(6'h3F);
        step(S + 2 + RD_LAT + 1);
        check("read_0x3f", {24'd0, io_data_o}, 32'h81);
        rd_end();

        // Write strobe rising while the read is being driven.
        rd_begin(6'h39);
        step(S + 2 + RD_LAT + 1);
        base_we = we_count;
        mprj_io[IO_WR_BIT] = 1'b1;
        step(S + 3);
        check("overlap_err", {31'd0, err_o}, 1);
        check("overlap_data", {24'd0, io_data_o}, 32'hFA);
        check("overlap_oeb", {24'd0, io_data_oeb}, 32'h00);
        mprj_io[IO_WR_BIT] = 1'b0;
        step(2);
        rd_end();
        check("overlap_no_write", we_count - base_we, 0);

        // Reset while waiting for read data.
        rd_begin(6'h39);
        step(S + 2);
        @(negedge clk);
        #1;
        rst = 1'b1;
        mprj_io[IO_RD_BIT] = 1'b0;
        @(posedge clk);
        #1;
        check_reset("midread");
        rst = 1'b0;
        step(2);
        rd_begin(6'h18);
        step(S + 2 + RD_LAT + 1);
        check("after_reset_read", {24'd0, io_data_o}, 32'hEA);
        rd_end();

        // Both strobes rising together.
        base_we = we_count;
        base_re = re_count;
        check("pre_simul_err", {31'd0, err_o}, 0);
        step(S + 1);
        busy_seen = 1'b0;
        mprj_io[IO_WR_BIT] = 1'b1;
        mprj_io[IO_RD_BIT] = 1'b1;
        step(S + 3);
        check("simul_err", {31'd0, err_o}, 1);
        check("simul_busy_seen", {31'd0, busy_seen}, 0);
        check("simul_no_ops", (we_count - base_we) + (re_count - base_re), 0);
        mprj_io[IO_WR_BIT] = 1'b0;
        mprj_io[IO_RD_BIT] = 1'b0;
        step(S + 2);
        check("simul_err_sticky", {31'd0, err_o}, 1);

        // Parity of returned data.
        pad_write(6'h05, 8'h6A, 3);
        pad_write(6'h06, 8'h6B, 3);
        rd_begin(6'h05);
        step(S + 2 + RD_LAT + 1);
        check("par_data_6a", {24'd0, io_data_o}, 32'h6A);
        check("par_6a", {31'd0, rd_par_o}, 0);
        rd_end();
        rd_begin(6'h06);
        step(S + 2 + RD_LAT + 1);
        check("par_data_6b", {24'd0, io_data_o}, 32'h6B);
`ifdef MEM_IO_PARITY_EN
        check("par_6b", {31'd0, rd_par_o}, 1);
`else
        check("par_6b", {31'd0, rd_par_o}, 0);
`endif
        rd_end();
        check("par_cleared", {31'd0, rd_par_o}, 0);

        step(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
